// File: rtl/i_ram_loader_pkg.sv
// Shared definitions for the instruction-RAM boot loader: FSM states and the
// byte layout of a program frame, so host tools and RTL agree on framing.
package i_ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_D_HI,
    ST_D_LO,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Byte offsets within a frame; data words follow as HI,LO pairs, then CHK.
  localparam int FRAME_OFS_SYNC   = 0;
  localparam int FRAME_OFS_LEN_HI = 1;
  localparam int FRAME_OFS_LEN_LO = 2;
  localparam int FRAME_OFS_DATA   = 3;
  localparam int FRAME_OVERHEAD   = 4;

  function automatic int frame_bytes(input int n_words);
    return FRAME_OVERHEAD + 2 * n_words;
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: down-counter reloaded on every byte (or while not
// running); flags expiry after TIMEOUT_CYCLES idle clocks. 0 disables it.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (!run || kick) begin
        cnt_d = LOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= LOAD;
      else        cnt_q <= cnt_d;
    end

    // Terminal count reached on the TIMEOUT_CYCLES-th idle clock.
    assign expired = run && !kick && (cnt_q == '0);
  end

endmodule

// File: rtl/i_ram_loader.sv
// Boot loader: parses framed program bytes from the UART, writes 16-bit words
// into instruction RAM and releases the CPU only after a good checksum.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | waiting for SYNC_BYTE, all other bytes ignored
//   ST_LEN_HI | expecting word-count high byte
//   ST_LEN_LO | expecting word-count low byte, range check
//   ST_D_HI   | expecting high byte of next data word
//   ST_D_LO   | expecting low byte, issues the RAM write
//   ST_CHK    | expecting checksum byte
//   ST_DONE   | one-cycle success, done pulse, CPU released
//   ST_ERR    | one-cycle failure, error set, CPU held
module i_ram_loader
  import i_ram_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 12,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [15:0]           w_data,
  output logic                  w_en,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int          CW        = ADDR_WIDTH + 1;
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            sum_q, sum_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [15:0]           w_data_q, w_data_d;
  logic                  w_en_q, w_en_d;
  logic                  error_q, error_d;
  logic                  hold_q, hold_d;

  logic                  tmo_run, tmo_expired;
  logic [16:0]           n_rx;
  logic [CW-1:0]         wcnt_inc;
  logic [7:0]            sum_rx;

  assign tmo_run = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                   (state_q == ST_D_HI)   || (state_q == ST_D_LO)   ||
                   (state_q == ST_CHK);

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (tmo_run),
    .kick    (rx_valid),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    hi_d     = hi_q;
    sum_d    = sum_q;
    wcnt_d   = wcnt_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    w_en_d   = 1'b0;
    error_d  = error_q;
    hold_d   = hold_q;
    n_rx     = {1'b0, len_q[15:8], rx_data};
    wcnt_inc = wcnt_q + CW'(1);
    sum_rx   = sum_q + rx_data;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ST_LEN_HI;
          hold_d  = 1'b1;
          error_d = 1'b0;
          wcnt_d  = '0;
          sum_d   = '0;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          state_d     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          if (n_rx > MAX_WORDS) state_d = ST_ERR;
          else if (n_rx == '0)  state_d = ST_CHK;
          else                  state_d = ST_D_HI;
        end
      end
      ST_D_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          sum_d   = sum_rx;
          state_d = ST_D_LO;
        end
      end
      ST_D_LO: begin
        if (rx_valid) begin
          w_en_d   = 1'b1;
          w_addr_d = wcnt_q[ADDR_WIDTH-1:0];
          w_data_d = {hi_q, rx_data};
          sum_d    = sum_rx;
          wcnt_d   = wcnt_inc;
          state_d  = (17'(wcnt_inc) == {1'b0, len_q}) ? ST_CHK : ST_D_HI;
        end
      end
      ST_CHK: begin
        if (rx_valid) state_d = (sum_rx == 8'd0) ? ST_DONE : ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Expiry only fires on clocks with no byte, so it never races a transition.
    if (tmo_expired)          state_d = ST_ERR;
    if (state_d == ST_ERR)    error_d = 1'b1;
    if (state_d == ST_DONE)   hold_d  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      hi_q     <= '0;
      sum_q    <= '0;
      wcnt_q   <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_en_q   <= 1'b0;
      error_q  <= 1'b0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      hi_q     <= hi_d;
      sum_q    <= sum_d;
      wcnt_q   <= wcnt_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_en_q   <= w_en_d;
      error_q  <= error_d;
      hold_q   <= hold_d;
    end
  end

  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign w_en     = w_en_q;
  assign cpu_hold = hold_q;
  assign error    = error_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule
